// File: rtl/subpel_row_fetch_ctrl_if.sv
// Frame-memory read port and interpolator row handshake for subpel_row_fetch_ctrl.
// master = the fetch controller, slave = memory / interpolator side.
interface subpel_row_fetch_ctrl_if #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned ROW_PIX = 15,
   parameter int unsigned ADDR_W  = 9
);
   logic                       mem_req;
   logic                       mem_ack;
   logic [ADDR_W-1:0]          mem_row;
   logic [11:0]                mem_col;
   logic                       mem_rvalid;
   logic [PIX_W*ROW_PIX-1:0]   mem_rdata;
   logic                       row_valid;
   logic                       row_ready;
   logic [PIX_W*ROW_PIX-1:0]   row_data;
   logic [7:0]                 row_idx;
   logic                       row_last;

   modport master (
      output mem_req, mem_row, mem_col,
      input  mem_ack, mem_rvalid, mem_rdata,
      output row_valid, row_data, row_idx, row_last,
      input  row_ready
   );

   modport slave (
      input  mem_req, mem_row, mem_col,
      output mem_ack, mem_rvalid, mem_rdata,
      input  row_valid, row_data, row_idx, row_last,
      output row_ready
   );
endinterface

// File: rtl/subpel_row_fetch_ctrl.sv
// Flow-controlled fetch of the 15 reference rows per 8x8 block for the sub-pel FIR.
// Optional macro SUBPEL_ROW_CLAMP_EN clamps row addresses to the frame (edge replication).
module subpel_row_fetch_ctrl #(
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned ROW_PIX    = 15,
   parameter int unsigned NUM_ROWS   = 15,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FRAME_H    = 300,
   parameter int unsigned ADDR_W     = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [11:0]             blk_y,
   input  logic [11:0]             blk_x,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   subpel_row_fetch_ctrl_if.master bus
);

   localparam int unsigned CNT_W  = $clog2(NUM_ROWS + 1);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned ROW_W  = PIX_W * ROW_PIX;
   localparam logic signed [12:0] Y_MAX = 13'(FRAME_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t             state, nxt_state;
   logic [CNT_W-1:0]   req_cnt, rsp_cnt, out_cnt;
   logic [CNT_W-1:0]   nxt_req_cnt, nxt_rsp_cnt, nxt_out_cnt;
   logic [CNT_W-1:0]   outstanding;
   logic [FCNT_W-1:0]  fcnt, nxt_fcnt;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [ROW_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [CNT_W-1:0]   fifo_tag  [FIFO_DEPTH];
   logic [11:0]        y_base, nxt_y;
   logic signed [12:0] nxt_sum;
   logic [ADDR_W-1:0]  nxt_addr;
   logic [CNT_W:0]     nxt_credit;
   logic               start_ok, req_fire, push, pop, spurious;

   // Request outputs are registered from next-cycle counter values so mem_req
   // tracks the credit rule without an extra cycle of lag.
   always_comb begin
      outstanding = req_cnt - rsp_cnt;
      start_ok    = (state == S_IDLE) && start;
      req_fire    = bus.mem_req && bus.mem_ack;
      push        = bus.mem_rvalid && (outstanding != '0);
      spurious    = bus.mem_rvalid && (outstanding == '0);
      pop         = bus.row_valid && bus.row_ready;

      nxt_req_cnt = req_cnt;
      nxt_rsp_cnt = rsp_cnt;
      nxt_out_cnt = out_cnt;
      nxt_y       = y_base;
      nxt_state   = state;

      if (start_ok) begin
         nxt_req_cnt = '0;
         nxt_rsp_cnt = '0;
         nxt_out_cnt = '0;
         nxt_y       = blk_y;
      end else begin
         if (req_fire) nxt_req_cnt = req_cnt + 1'b1;
         if (push)     nxt_rsp_cnt = rsp_cnt + 1'b1;
         if (pop)      nxt_out_cnt = out_cnt + 1'b1;
      end

      case ({push, pop})
         2'b10:   nxt_fcnt = fcnt + 1'b1;
         2'b01:   nxt_fcnt = fcnt - 1'b1;
         default: nxt_fcnt = fcnt;
      endcase

      case (state)
         S_IDLE:  if (start) nxt_state = S_FETCH;
         S_FETCH: if (nxt_req_cnt == CNT_W'(NUM_ROWS)) nxt_state = S_DRAIN;
         S_DRAIN: if (nxt_out_cnt == CNT_W'(NUM_ROWS)) nxt_state = S_DONE;
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase

      nxt_sum    = {nxt_y[11], nxt_y} + {{(13 - CNT_W){1'b0}}, nxt_req_cnt};
      nxt_credit = {1'b0, nxt_req_cnt - nxt_rsp_cnt} + (CNT_W + 1)'(nxt_fcnt);
   end

`ifdef SUBPEL_ROW_CLAMP_EN
   always_comb begin
      if (nxt_sum[12])
         nxt_addr = '0;
      else if (nxt_sum > Y_MAX)
         nxt_addr = ADDR_W'(Y_MAX);
      else
         nxt_addr = nxt_sum[ADDR_W-1:0];
   end
`else
   logic unused_hi;
   assign unused_hi = ^{nxt_sum[12:ADDR_W], Y_MAX};

   always_comb begin
      nxt_addr = nxt_sum[ADDR_W-1:0];
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         req_cnt     <= '0;
         rsp_cnt     <= '0;
         out_cnt     <= '0;
         y_base      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         bus.mem_req <= 1'b0;
         bus.mem_row <= '0;
         bus.mem_col <= '0;
      end else begin
         state       <= nxt_state;
         req_cnt     <= nxt_req_cnt;
         rsp_cnt     <= nxt_rsp_cnt;
         out_cnt     <= nxt_out_cnt;
         y_base      <= nxt_y;
         busy        <= (nxt_state != S_IDLE);
         done        <= (nxt_state == S_DONE);
         if (spurious) err <= 1'b1;
         if (start_ok) bus.mem_col <= blk_x;
         bus.mem_req <= (nxt_state == S_FETCH) && (nxt_credit < (CNT_W + 1)'(FIFO_DEPTH));
         bus.mem_row <= nxt_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fcnt   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_tag[i]  <= '0;
         end
      end else begin
         fcnt <= nxt_fcnt;
         if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rdata;
            fifo_tag[wr_ptr]  <= rsp_cnt;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_comb begin
      bus.row_valid = (fcnt != '0);
      bus.row_data  = fifo_data[rd_ptr];
      bus.row_idx   = 8'(fifo_tag[rd_ptr]);
      bus.row_last  = bus.row_valid && (fifo_tag[rd_ptr] == CNT_W'(NUM_ROWS - 1));
   end

endmodule

// File: tb/tb_subpel_row_fetch_ctrl.sv
// Scoreboard bench for subpel_row_fetch_ctrl: memory model, row monitor, directed blocks.
// Expectations follow SUBPEL_ROW_CLAMP_EN when it is defined.
module tb_subpel_row_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [11:0] blk_y = '0;
   logic [11:0] blk_x = '0;
   logic        busy, done, err;

   subpel_row_fetch_ctrl_if #(.PIX_W(8), .ROW_PIX(15), .ADDR_W(9)) bus ();

   subpel_row_fetch_ctrl #(
      .PIX_W(8), .ROW_PIX(15), .NUM_ROWS(15), .FIFO_DEPTH(4), .FRAME_H(300), .ADDR_W(9)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .blk_y(blk_y), .blk_x(blk_x),
      .busy(busy), .done(done), .err(err), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct { logic [119:0] data; logic [7:0] idx; logic last; } row_t;
   typedef struct { logic [8:0] row; logic [11:0] col; } req_t;
   typedef struct { logic [8:0] row; int due; } pend_t;

   req_t  req_q[$];
   row_t  row_q[$];
   pend_t pend_q[$];

   function automatic logic [119:0] word_of(input logic [8:0] a);
      logic [119:0] w;
      for (int p = 0; p < 15; p++) w[p*8 +: 8] = a[7:0] ^ 8'(p * 17) ^ {a[8], 7'd0};
      return w;
   endfunction

   function automatic logic [8:0] exp_row(input int y, input int k);
      int s;
      s = y + k;
`ifdef SUBPEL_ROW_CLAMP_EN
      if (s < 0) s = 0;
      if (s > 299) s = 299;
`endif
      return 9'(s);
   endfunction

   // memory model knobs
   int fix_lat = 1;
   bit rand_lat = 0, rand_ack = 0, freeze = 0, spur = 0;
   int cyc = 0, last_due = -1;

   initial begin : mem_model
      bit         fire;
      logic [8:0] frow;
      int         lat, due;
      pend_t      p;
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         fire = bus.mem_req && bus.mem_ack;
         frow = bus.mem_row;
         @(posedge clk);
         cyc++;
         #1;
         if (fire) begin
            lat = rand_lat ? int'($urandom_range(1, 5)) : fix_lat;
            due = cyc + lat - 1;
            if (due <= last_due) due = last_due + 1;
            pend_q.push_back('{frow, due});
            last_due = due;
         end
         bus.mem_rvalid = 1'b0;
         if (spur) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = {120{1'b1}};
            spur = 0;
         end else if (!freeze && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = word_of(p.row);
         end
         bus.mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   int         rows_seen = 0, done_cnt = 0, req_seen = 0;
   logic [8:0] first_row, last_row;
   bit         first_flag = 0;

   initial begin : monitor
      bit           hold_req, hold_row;
      logic [8:0]   h_row;
      logic [11:0]  h_col;
      logic [119:0] h_data;
      logic [7:0]   h_idx;
      req_t         er;
      row_t         ew;
      hold_req = 0;
      hold_row = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold_req = 0;
            hold_row = 0;
            continue;
         end
         if (hold_req) begin
            chk("req_hold", bus.mem_req, 1'b1);
            chk("row_hold", bus.mem_row, h_row);
            chk("col_hold", bus.mem_col, h_col);
         end
         if (hold_row) begin
            chk("valid_hold", bus.row_valid, 1'b1);
            chk("data_hold", bus.row_data, h_data);
            chk("idx_hold", bus.row_idx, h_idx);
         end
         if (bus.mem_req && bus.mem_ack) begin
            if (req_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_req: got row %0d, expected no request", bus.mem_row);
            end else begin
               er = req_q.pop_front();
               chk("mem_row", bus.mem_row, er.row);
               chk("mem_col", bus.mem_col, er.col);
            end
            if (!first_flag) first_row = bus.mem_row;
            first_flag = 1;
            last_row = bus.mem_row;
            req_seen++;
         end
         hold_req = bus.mem_req && !bus.mem_ack;
         h_row    = bus.mem_row;
         h_col    = bus.mem_col;
         if (bus.row_valid && bus.row_ready) begin
            if (row_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_row: got idx %0d, expected no row", bus.row_idx);
            end else begin
               ew = row_q.pop_front();
               chk("row_data", bus.row_data, ew.data);
               chk("row_idx", bus.row_idx, ew.idx);
               chk("row_last", bus.row_last, ew.last);
            end
            rows_seen++;
         end
         hold_row = bus.row_valid && !bus.row_ready;
         h_data   = bus.row_data;
         h_idx    = bus.row_idx;
         if (done) done_cnt++;
      end
   end

   task automatic launch(input int y, input int x);
      for (int k = 0; k < 15; k++) begin
         req_q.push_back('{exp_row(y, k), 12'(x)});
         row_q.push_back('{word_of(exp_row(y, k)), 8'(k), (k == 14)});
      end
      @(posedge clk);
      #1;
      blk_y = 12'(y);
      blk_x = 12'(x);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n;
      for (n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done) break;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
      end
      @(posedge clk);
      #1;
      chk({nm, "_req_q_left"}, req_q.size(), 0);
      chk({nm, "_row_q_left"}, row_q.size(), 0);
      chk({nm, "_busy_after"}, busy, 1'b0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_done"}, done, 1'b0);
      chk({nm, "_err"}, err, 1'b0);
      chk({nm, "_mem_req"}, bus.mem_req, 1'b0);
      chk({nm, "_mem_row"}, bus.mem_row, 9'd0);
      chk({nm, "_mem_col"}, bus.mem_col, 12'd0);
      chk({nm, "_row_valid"}, bus.row_valid, 1'b0);
      chk({nm, "_row_data"}, bus.row_data, 120'd0);
      chk({nm, "_row_idx"}, bus.row_idx, 8'd0);
      chk({nm, "_row_last"}, bus.row_last, 1'b0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n, tv, td, rs0, dc0;
      bus.row_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b1;

      // basic: ideal handshakes
      first_flag = 0;
      launch(0, 40);
      n = 1; tv = 0; td = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.row_valid && tv == 0) tv = n;
         if (done) begin
            td = n;
            break;
         end
         @(posedge clk);
         n++;
      end
      chk("first_valid_latency", tv, 3);
      chk("done_latency", td, 18);
      chk("basic_first_row", first_row, 9'd0);
      chk("basic_last_row", last_row, 9'd14);
      @(posedge clk);
      #1;
      chk("basic_req_q_left", req_q.size(), 0);
      chk("basic_row_q_left", row_q.size(), 0);
      chk("basic_busy_after", busy, 1'b0);

      // backpressure: ready low until buffer + outstanding saturates
      bus.row_ready = 1'b0;
      rs0 = req_seen;
      launch(20, 7);
      for (n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.row_valid) break;
      end
      chk("bp_valid_seen", bus.row_valid, 1'b1);
      repeat (10) @(negedge clk);
      chk("bp_req_stalled", bus.mem_req, 1'b0);
      chk("bp_req_count", req_seen - rs0, 4);
      chk("bp_valid_held", bus.row_valid, 1'b1);
      chk("bp_idx_head", bus.row_idx, 8'd0);
      @(posedge clk);
      #1;
      bus.row_ready = 1'b1;
      wait_done("bp", 100);

      // random ack and latency
      rand_ack = 1;
      rand_lat = 1;
      launch(100, 300);
      wait_done("rand", 400);
      rand_ack = 0;
      rand_lat = 0;
      chk("rand_err", err, 1'b0);

      // window above the frame top
      first_flag = 0;
      launch(-3, 0);
      wait_done("neg", 100);
`ifdef SUBPEL_ROW_CLAMP_EN
      chk("neg_first_row", first_row, 9'd0);
`else
      chk("neg_first_row", first_row, 9'd509);
`endif
      chk("neg_last_row", last_row, 9'd11);

      // window below the frame bottom
      first_flag = 0;
      launch(290, 0);
      wait_done("bot", 100);
      chk("bot_first_row", first_row, 9'd290);
`ifdef SUBPEL_ROW_CLAMP_EN
      chk("bot_last_row", last_row, 9'd299);
`else
      chk("bot_last_row", last_row, 9'd304);
`endif

      // start while busy is ignored
      dc0 = done_cnt;
      launch(50, 5);
      repeat (4) @(posedge clk);
      #1;
      blk_y = 12'd200;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_start", 100);
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("busy_start_done_count", done_cnt - dc0, 1);
      chk("busy_start_req_q_left", req_q.size(), 0);

      // spurious rvalid in IDLE
      chk("err_before_spur", err, 1'b0);
      spur = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("spur_err", err, 1'b1);
      chk("spur_fifo_empty", bus.row_valid, 1'b0);
      chk("spur_busy", busy, 1'b0);

      // asynchronous reset mid-block, stale responses afterwards
      fix_lat = 3;
      rs0 = rows_seen;
      launch(60, 9);
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (rows_seen - rs0 >= 6) break;
      end
      chk("mid_rows_before_reset", rows_seen - rs0, 6);
      freeze = 1;
      #2;
      rst = 1'b0;
      #1;
      chk_zero("midrst");
      req_q.delete();
      row_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      freeze = 0;
      for (n = 0; n < 40; n++) begin
         @(posedge clk);
         if (pend_q.size() == 0) break;
      end
      @(negedge clk);
      chk("stale_err", err, 1'b1);
      chk("stale_no_row", bus.row_valid, 1'b0);

      // fresh block after reset
      fix_lat = 1;
      rs0 = rows_seen;
      launch(120, 11);
      wait_done("after_rst", 100);
      chk("after_rst_rows", rows_seen - rs0, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
